ht_cmd_arbiter: RTL and testbench

- Shares the single hash-calculation stage of the hash table between NUM_REQ independent command sources (host ports, rehash engine, aging scanner).
- Grants one valid command per cycle, round-robin. Stamps the winning source index on the command. Presents it through a 1-deep registered output with valid/ready to the hash stage input.
- Tracks per-source in-flight commands against a credit limit. Credits return on completion notifications from the pipeline tail.

---
 rtl/ht_cmd_arbiter.sv | 132 +++++++++++++
 tb/tb_ht_cmd_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_arbiter.sv
// Round-robin arbiter sharing the hash stage among NUM_REQ command sources, with per-source credits.
// Accept to out_valid_o is one cycle; a held, unaccepted output blocks all grants until out_ready_i.
module ht_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int D_WIDTH = 64,
    parameter int MAX_OUT = 2,
    localparam int SRC_W = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ*D_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [D_WIDTH-1:0]         out_data_o,
    output logic [SRC_W-1:0]           out_src_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       done_valid_i,
    input  logic [SRC_W-1:0]           done_src_i,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [D_WIDTH-1:0] req_dat [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] cnt_nz;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               load;
    logic [31:0]        idx;
    logic               inc, dec;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    always_comb begin
        for (int s = 0; s < NUM_REQ; s++) begin
            req_dat[s] = req_data_i[s*D_WIDTH +: D_WIDTH];
            elig[s]    = req_valid_i[s] && (cnt_q[s] < CNT_W'(MAX_OUT));
            cnt_nz[s]  = (cnt_q[s] != '0);
        end
    end

    // Scan starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        load      = !out_valid_q || out_ready_i;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 32'((int'(ptr_q) + k) % NUM_REQ);
            if (load && !grant_vld && elig[idx[SRC_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[SRC_W-1:0];
            end
        end
        req_ready_o = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (grant_vld) begin
            out_data_d  = req_dat[grant_idx];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = grant_idx;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // A done is only honoured against a non-zero count; anything else is a protocol error.
    always_comb begin
        err_d = err_q;
        inc   = 1'b0;
        dec   = 1'b0;
        if (done_valid_i) begin
            if ({1'b0, done_src_i} >= (SRC_W+1)'(NUM_REQ)) begin
                err_d = 1'b1;
            end else if (cnt_q[done_src_i] == '0) begin
                err_d = 1'b1;
            end
        end
        for (int s = 0; s < NUM_REQ; s++) begin
            inc      = grant_vld && (grant_idx == SRC_W'(s));
            dec      = done_valid_i && (done_src_i == SRC_W'(s)) && (cnt_q[s] != '0);
            cnt_d[s] = cnt_q[s];
            if (inc && !dec) begin
                cnt_d[s] = cnt_q[s] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SRC_W'(NUM_REQ - 1);
            err_q       <= 1'b0;
            for (int s = 0; s < NUM_REQ; s++) begin
                cnt_q[s] <= '0;
            end
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            for (int s = 0; s < NUM_REQ; s++) begin
                cnt_q[s] <= cnt_d[s];
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;
    assign busy_o      = out_valid_q || (|cnt_nz);

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Randomised bench for ht_cmd_arbiter against a queue-free behavioural model of arbitration and credits.
module tb_ht_cmd_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int MO = 2;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready_o;
    logic [DW-1:0]   out_data_o;
    logic [1:0]      out_src_o;
    logic            out_valid_o;
    logic            out_ready = 1'b0;
    logic            done_valid = 1'b0;
    logic [1:0]      done_src = '0;
    logic            busy_o, err_o;

    logic [5*DW-1:0] req_data5 = '0;
    logic [4:0]      req_valid5 = '0;
    logic [4:0]      req_ready5;
    logic [DW-1:0]   out_data5;
    logic [2:0]      out_src5;
    logic            out_valid5;
    logic            done_valid5 = 1'b0;
    logic [2:0]      done_src5 = '0;
    logic            busy5, err5;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cnt [NR];
    int          m_ptr;
    bit          m_vld;
    logic [DW-1:0] m_dat;
    int          m_src;
    bit          m_err;

    always #5 clk_i = ~clk_i;

    ht_cmd_arbiter #(.NUM_REQ(NR), .D_WIDTH(DW), .MAX_OUT(MO)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .out_data_o(out_data_o), .out_src_o(out_src_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready), .done_valid_i(done_valid), .done_src_i(done_src),
        .busy_o(busy_o), .err_o(err_o)
    );

    ht_cmd_arbiter #(.NUM_REQ(5), .D_WIDTH(DW), .MAX_OUT(MO)) u_dut5 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_data_i(req_data5), .req_valid_i(req_valid5), .req_ready_o(req_ready5),
        .out_data_o(out_data5), .out_src_o(out_src5), .out_valid_o(out_valid5),
        .out_ready_i(1'b1), .done_valid_i(done_valid5), .done_src_i(done_src5),
        .busy_o(busy5), .err_o(err5)
    );

    function automatic void model_reset();
        for (int s = 0; s < NR; s++) m_cnt[s] = 0;
        m_ptr = NR - 1;
        m_vld = 0;
        m_dat = '0;
        m_src = 0;
        m_err = 0;
    endfunction

    function automatic int exp_grant();
        if (m_vld && !out_ready) return -1;
        for (int k = 1; k <= NR; k++) begin
            int s;
            s = (m_ptr + k) % NR;
            if (req_valid[s] && m_cnt[s] < MO) return s;
        end
        return -1;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_vld;
        for (int s = 0; s < NR; s++) if (m_cnt[s] != 0) b = 1;
        return b;
    endfunction

    // One clock: compare the combinational grant, advance the model, compare registered outputs.
    task automatic step();
        int g;
        int ds;
        logic [NR-1:0] er;
        #1;
        g  = exp_grant();
        er = (g >= 0) ? (NR'(1) << g) : '0;
        checks++;
        if (req_ready_o !== er) begin
            errors++;
            $display("FAIL req_ready t=%0t got=%b exp=%b", $time, req_ready_o, er);
        end
        @(posedge clk_i);
        ds = -1;
        if (done_valid) begin
            if (int'(done_src) >= NR || m_cnt[done_src] == 0) m_err = 1;
            else ds = int'(done_src);
        end
        if (ds >= 0) m_cnt[ds]--;
        if (g >= 0) begin
            m_cnt[g]++;
            m_vld = 1;
            m_dat = req_data[g*DW +: DW];
            m_src = g;
            m_ptr = g;
        end else if (!m_vld || out_ready) begin
            m_vld = 0;
        end
        #1;
        checks++;
        if (out_valid_o !== m_vld) begin
            errors++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid_o, m_vld);
        end
        if (m_vld) begin
            checks++;
            if (out_data_o !== m_dat || int'(out_src_o) != m_src) begin
                errors++;
                $display("FAIL out_payload t=%0t got=%h/%0d exp=%h/%0d", $time, out_data_o, out_src_o, m_dat, m_src);
            end
        end
        checks++;
        if (busy_o !== model_busy() || err_o !== m_err) begin
            errors++;
            $display("FAIL busy_err t=%0t got=%b/%b exp=%b/%b", $time, busy_o, err_o, model_busy(), m_err);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i    = 1'b0;
        req_valid  = '0;
        out_ready  = 1'b0;
        done_valid = 1'b0;
        done_valid5 = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_src_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got vld=%b dat=%h src=%0d busy=%b err=%b exp all zero",
                     out_valid_o, out_data_o, out_src_o, busy_o, err_o);
        end
        req_valid = '1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL reset_priority got=%b exp=0001", req_ready_o);
        end
        step();
    endtask

    task automatic test_single_source();
        do_reset();
        req_data[2*DW +: DW] = 64'hA;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready got=%b exp=0100", req_ready_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 64'hA || out_src_o !== 2'd2) begin
            errors++;
            $display("FAIL single_out got=%b/%h/%0d exp=1/a/2", out_valid_o, out_data_o, out_src_o);
        end
        step();
        step();
        checks++;
        if (req_ready_o !== 4'b0000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL credit_block got ready=%b busy=%b exp 0000/1", req_ready_o, busy_o);
        end
        done_valid = 1'b1;
        done_src   = 2'd2;
        step();
        done_valid = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL credit_resume got=%b exp=0100", req_ready_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int s = 0; s < NR; s++) req_data[s*DW +: DW] = {$urandom, $urandom};
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            done_valid = m_vld;
            done_src   = 2'(m_src);
            step();
            checks++;
            if (out_valid_o !== 1'b1 || int'(out_src_o) != i % NR) begin
                errors++;
                $display("FAIL rr_seq i=%0d got=%b/%0d exp=1/%0d", i, out_valid_o, out_src_o, i % NR);
            end
        end
        done_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held_dat;
        logic [1:0]    held_src;
        do_reset();
        for (int s = 0; s < NR; s++) req_data[s*DW +: DW] = {$urandom, $urandom};
        req_valid = 4'b0010;
        out_ready = 1'b1;
        step();
        held_dat  = out_data_o;
        held_src  = out_src_o;
        req_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_data[0 +: DW] = {$urandom, $urandom};
            step();
            checks++;
            if (out_data_o !== held_dat || out_src_o !== held_src || out_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable i=%0d got=%h/%0d exp=%h/%0d", i, out_data_o, out_src_o, held_dat, held_src);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_src_o !== 2'd2) begin
            errors++;
            $display("FAIL bp_release got src=%0d exp=2", out_src_o);
        end
    endtask

    task automatic test_grant_done_same();
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        step();
        done_valid = 1'b1;
        done_src   = 2'd1;
        step();
        done_valid = 1'b0;
        step();
        checks++;
        if (req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL same_cycle_count got ready=%b exp=0000", req_ready_o);
        end
    endtask

    task automatic test_stray_done();
        do_reset();
        out_ready  = 1'b1;
        done_valid = 1'b1;
        done_src   = 2'd3;
        step();
        done_valid = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL stray_err got=%b exp=1", err_o);
        end
        req_valid = 4'b1000;
        step();
        step();
        step();
        checks++;
        if (err_o !== 1'b1 || req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL stray_sticky got err=%b ready=%b exp 1/0000", err_o, req_ready_o);
        end
        checks++;
        if (err5 !== 1'b0) begin
            errors++;
            $display("FAIL range_err_pre got=%b exp=0", err5);
        end
        done_valid5 = 1'b1;
        done_src5   = 3'd5;
        @(posedge clk_i);
        #1;
        done_valid5 = 1'b0;
        checks++;
        if (err5 !== 1'b1 || busy5 !== 1'b0) begin
            errors++;
            $display("FAIL range_err got err=%b busy=%b exp 1/0", err5, busy5);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        #3;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got vld=%b busy=%b err=%b exp 0/0/0", out_valid_o, busy_o, err_o);
        end
        model_reset();
        #1;
        rst_n_i = 1'b1;
        step();
        checks++;
        if (out_src_o !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_prio got src=%0d exp=0", out_src_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NR; s++) req_data[s*DW +: DW] = {$urandom, $urandom};
            req_valid  = 4'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            done_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                int s;
                s = $urandom_range(0, NR - 1);
                if (m_cnt[s] != 0) begin
                    done_valid = 1'b1;
                    done_src   = 2'(s);
                end
            end
            step();
        end
        done_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_source();
        test_back_to_back();
        test_backpressure();
        test_grant_done_same();
        test_stray_done();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
